// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a retired-instruction counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state and raise illegal_o.
module multicycle_control_unit #(
  parameter int OPCODE_W = 7,
  parameter int CNT_W    = 32,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic [2:0]          state_o,
  output logic                mem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_2_reg,
  output logic                jump,
  output logic [CNT_W-1:0]    retire_cnt
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_o
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd5;
`endif

  localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2'b00);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2'b01);
  localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2'b10);

  logic [2:0]          state, next_state;
  logic [OPCODE_W-1:0] opcode_q;
  logic                retire;
  logic                is_load;
  logic                legal;

  assign is_load = (opcode_q == OP_LOAD);
  assign legal   = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
  assign state_o = state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = (state == S_TRAP);
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_FETCH;
      opcode_q   <= '0;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) opcode_q <= opcode;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // ir_write/pc_write are gated by arst_n so reset shows FETCH outputs as if memory were not ready.
  always_comb begin
    next_state    = state;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    mem_2_reg     = 1'b0;
    jump          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & arst_n;
        pc_write  = mem_ready & arst_n;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        next_state = legal ? S_EXEC : S_TRAP;
`else
        next_state = legal ? S_EXEC : S_FETCH;
`endif
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (opcode_q)
          OP_R: begin
            alu_src_a  = 2'b01;
            alu_op     = ALU_R;
            next_state = S_WB;
          end
          OP_I: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_op     = ALU_R;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            next_state = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a     = 2'b01;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            retire        = 1'b1;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            jump     = 1'b1;
            retire   = 1'b1;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_read  = is_load;
        mem_write = !is_load;
        if (mem_ready) begin
          if (is_load) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_2_reg  = is_load;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: next_state = S_TRAP;
`endif
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus randomized
// instruction streams checked against a per-instruction cycle-table model.
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [2:0]  st;
    logic        rdy;
    logic [16:0] ctl;
  } cyc_t;

  logic             clk;
  logic             arst_n;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic [2:0]       state_o;
  logic             mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic             pc_write_cond, pc_src, reg_write, mem_2_reg, jump;
  logic [1:0]       alu_src_a, alu_src_b, alu_op;
  logic [CNT_W-1:0] retire_cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic             illegal_o;
`endif
  logic [16:0]      obs_ctl;

  int               n_cmp = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  multicycle_control_unit #(.OPCODE_W(7), .CNT_W(CNT_W), .ALU_OP_W(2)) dut (
    .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready),
    .state_o(state_o), .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_2_reg(mem_2_reg), .jump(jump), .retire_cnt(retire_cnt)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  assign obs_ctl = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                    pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_2_reg, jump};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] pk(input logic req, rd, wr, iod, irw, pcw, pcwc, pcs,
                                     input logic [1:0] a, b, op,
                                     input logic rw, m2r, j);
    return {req, rd, wr, iod, irw, pcw, pcwc, pcs, a, b, op, rw, m2r, j};
  endfunction

  // 0 = illegal, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH_EQ, 6 JAL
  function automatic int op_kind(input logic [6:0] op);
    case (op)
      OP_R:      return 1;
      OP_I:      return 2;
      OP_LOAD:   return 3;
      OP_STORE:  return 4;
      OP_BRANCH: return 5;
      OP_JAL:    return 6;
      default:   return 0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    arst_n    = 1'b0;
    #2;
    @(negedge clk);
    arst_n  = 1'b1;
    exp_cnt = '0;
  endtask

  // Builds the expected cycle table for one instruction from the latency/output rules, then plays it.
  task automatic run_instr(input string tag, input logic [6:0] op, input int fw, input int mw);
    cyc_t q[$];
    int   k;
    logic ld;
    k  = op_kind(op);
    ld = (k == 3);
    for (int i = 0; i < fw; i++)
      q.push_back('{st: 3'd0, rdy: 1'b0, ctl: pk(1,1,0,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0)});
    q.push_back('{st: 3'd0, rdy: 1'b1, ctl: pk(1,1,0,0,1,1,0,0,2'b00,2'b01,2'b00,0,0,0)});
    q.push_back('{st: 3'd1, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0,0,0)});
    case (k)
      1: q.push_back('{st: 3'd2, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b10,0,0,0)});
      2: q.push_back('{st: 3'd2, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,0,0,0,2'b01,2'b10,2'b10,0,0,0)});
      3, 4: q.push_back('{st: 3'd2, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0)});
      5: q.push_back('{st: 3'd2, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,0,1,1,2'b01,2'b00,2'b01,0,0,0)});
      6: q.push_back('{st: 3'd2, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,1,0,1,2'b00,2'b00,2'b00,0,0,1)});
      default: ;
    endcase
    if (k == 3 || k == 4) begin
      for (int i = 0; i <= mw; i++)
        q.push_back('{st: 3'd3, rdy: (i == mw),
                      ctl: pk(1,ld,!ld,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,0)});
    end
    if (k == 1 || k == 2 || k == 3)
      q.push_back('{st: 3'd4, rdy: 1'($urandom), ctl: pk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,ld,0)});
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].rdy;
      opcode    = (q[i].st == 3'd1) ? op : 7'($urandom);
      #1;
      n_cmp++;
      if (state_o !== q[i].st) begin
        n_fail++;
        $display("FAIL %s state cyc%0d: got %0d, want %0d", tag, i, state_o, q[i].st);
      end
      n_cmp++;
      if (obs_ctl !== q[i].ctl) begin
        n_fail++;
        $display("FAIL %s ctl cyc%0d: got %05h, want %05h", tag, i, obs_ctl, q[i].ctl);
      end
      n_cmp++;
      if (retire_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s retire_cnt cyc%0d: got %0d, want %0d", tag, i, retire_cnt, exp_cnt);
      end
    end
    if (k != 0) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    arst_n    = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'($urandom);
    #3;
    n_cmp++;
    if (state_o !== 3'd0 || retire_cnt !== '0 ||
        obs_ctl !== pk(1,1,0,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0)) begin
      n_fail++;
      $display("FAIL reset: got st=%0d ctl=%05h cnt=%0d, want st=0 ctl=%05h cnt=0",
               state_o, obs_ctl, retire_cnt, pk(1,1,0,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0));
    end
    @(negedge clk);
    arst_n  = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_r_type();
    do_reset();
    run_instr("r_type", OP_R, 0, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (retire_cnt !== 4'd1 || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL r_type_retire: got cnt=%0d st=%0d, want cnt=1 st=0", retire_cnt, state_o);
    end
  endtask

  task automatic test_load_wait();
    run_instr("load_wait", OP_LOAD, 0, 3);
  endtask

  task automatic test_store_branch();
    logic [CNT_W-1:0] start;
    start = exp_cnt;
    run_instr("store", OP_STORE, 0, 0);
    run_instr("branch", OP_BRANCH, 0, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (retire_cnt !== start + 4'd2) begin
      n_fail++;
      $display("FAIL store_branch_retire: got %0d, want %0d", retire_cnt, start + 4'd2);
    end
  endtask

  task automatic test_jal();
    run_instr("jal", OP_JAL, 1, 0);
  endtask

  task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    opcode = 7'h7F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode    = 7'($urandom);
      #1;
      n_cmp++;
      if (state_o !== 3'd5 || illegal_o !== 1'b1 || obs_ctl !== 17'h0 || retire_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL trap cyc%0d: got st=%0d ill=%b ctl=%05h cnt=%0d, want st=5 ill=1 ctl=0 cnt=%0d",
                 i, state_o, illegal_o, obs_ctl, retire_cnt, exp_cnt);
      end
    end
    do_reset();
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || illegal_o !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_exit: got st=%0d ill=%b, want st=0 ill=0", state_o, illegal_o);
    end
`else
    run_instr("illegal", 7'h7F, 0, 0);
    run_instr("after_illegal", OP_I, 0, 0);
`endif
  endtask

  task automatic test_random();
    logic [6:0] legal_ops [6];
    logic [6:0] op;
    legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    for (int n = 0; n < 40; n++) begin
      op = legal_ops[$urandom_range(0, 5)];
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
`endif
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 16; n++) run_instr("wrap", OP_R, $urandom_range(0, 1), 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (retire_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap: got %0d, want 0", retire_cnt);
    end
  endtask

  task automatic test_reset_mid_store();
    run_instr("pre_store", OP_R, 0, 0);
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    opcode = OP_STORE;
    @(negedge clk);
    opcode = 7'($urandom);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 3'd3 || mem_write !== 1'b1 || retire_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL store_mem: got st=%0d wr=%b cnt=%0d, want st=3 wr=1 cnt=1",
               state_o, mem_write, retire_cnt);
    end
    #2;
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_write !== 1'b0 || state_o !== 3'd0 || retire_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got wr=%b st=%0d cnt=%0d, want wr=0 st=0 cnt=0",
               mem_write, state_o, retire_cnt);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (mem_write !== 1'b0 || reg_write !== 1'b0 || retire_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got wr=%b rw=%b cnt=%0d, want 0 0 0", mem_write, reg_write, retire_cnt);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    arst_n    = 1'b1;
    exp_cnt   = '0;
  endtask

  initial begin
    opcode = '0;
    test_reset();
    test_r_type();
    test_load_wait();
    test_store_branch();
    test_jal();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit for the RISC-V core: a Moore/Mealy FSM that sequences each instruction over several cycles (FETCH, DECODE, EXEC, MEM, WB) instead of decoding purely combinationally.
- Drives the shared-memory multicycle datapath and handshakes with a variable-latency memory port.
- Keeps the same opcode set and ALUOp encoding as the single-cycle unit.
- Adds a retired-instruction counter.

Parameters:
- OPCODE_W, 7: opcode width.
- CNT_W, 32: width of the retired-instruction counter.
- ALU_OP_W, 2: ALUOp width. Encoding: 00 ADD, 01 SUB, 10 R-type.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instr[6:0] from the instruction register. Valid from the DECODE cycle onward.
- mem_ready  in  1  memory completes the current request this cycle.
- state_o  out  3  current state (debug).
- mem_req  out  1  memory access request.
- mem_read  out  1  read access.
- mem_write  out  1  write access.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write if ALU zero (branch).
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU A source: 00 PC, 01 rs1, 10 old PC.
- alu_src_b  out  2  ALU B source: 00 rs2, 01 const 4, 10 imm.
- alu_op  out  ALU_OP_W  ALUOp.
- reg_write  out  1  register-file write.
- mem_2_reg  out  1  writeback select: 1 = memory data.
- jump  out  1  JAL in progress.
- retire_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5 (TRAP only with the optional feature). All other encodings return to FETCH on the next edge.
- Reset (arst_n low, takes effect immediately):
  - state = FETCH, opcode_q = 0, retire_cnt = 0.
  - Combinational outputs take their FETCH values with mem_ready = 0: mem_req = 1, mem_read = 1, alu_src_b = 01, all others 0.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req = 1, mem_read = 1, i_or_d = 0, alu_src_a = 00, alu_src_b = 01, alu_op = 00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - Latch opcode_q <= opcode.
  - Outputs: alu_src_a = 10, alu_src_b = 10, alu_op = 00 (branch/jump target computed into ALUOut).
  - If opcode is R, I, LOAD, STORE, BRANCH_EQ or JAL, go to EXEC; otherwise go to FETCH (illegal opcode, no retire).
- EXEC (decoded from opcode_q):
  - R: alu_src_a = 01, alu_src_b = 00, alu_op = 10; go to WB.
  - I: alu_src_a = 01, alu_src_b = 10, alu_op = 10; go to WB.
  - LOAD/STORE: alu_src_a = 01, alu_src_b = 10, alu_op = 00; go to MEM.
  - BRANCH_EQ: alu_src_a = 01, alu_src_b = 00, alu_op = 01, branch behaviour pc_write_cond = 1, pc_src = 1; go to FETCH and retire.
  - JAL: pc_write = 1, pc_src = 1, jump = 1; go to FETCH and retire.
- MEM:
  - Outputs: mem_req = 1, i_or_d = 1; mem_read = 1 for LOAD, mem_write = 1 for STORE.
  - Hold all outputs stable while mem_ready = 0.
  - When mem_ready = 1: LOAD goes to WB; STORE goes to FETCH and retires.
- WB: reg_write = 1; mem_2_reg = 1 for LOAD, else 0. Go to FETCH and retire.
- Retire: retire_cnt increments by 1 on the retiring edge and wraps modulo 2^CNT_W (all-ones -> 0).
- Latency with mem_ready always 1:
  - BRANCH / JAL: 3 cycles.
  - R / I / STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- The opcode input is ignored outside DECODE; changes during EXEC/MEM/WB have no effect.
- mem_ready is ignored outside FETCH and MEM.
- Reset asserted mid-instruction aborts it: no retire, and no reg_write or mem_write is asserted after reset assertion.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP is sticky; all outputs are 0 except state_o = 5.
  - An extra output illegal_o (1 bit) = 1 while in TRAP.
  - Only arst_n exits TRAP.
- Undefined:
  - No TRAP state and no illegal_o port.
  - An illegal opcode returns to FETCH as described in Behaviour.

Test Plan:
- Reset then R-type (opcode 0110011), mem_ready = 1 -> states 0,1,2,4,0; reg_write = 1 only in WB; retire_cnt = 1 after 4 cycles.
- LOAD (0000011) with mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_read = 1, i_or_d = 1 stable; WB mem_2_reg = 1; total 8 cycles.
- STORE (0100011) then BRANCH_EQ (1100011) -> mem_write = 1 exactly one cycle; branch EXEC alu_op = 01, pc_write_cond = 1; retire_cnt = 2 after 7 cycles.
- JAL (1101111) -> EXEC asserts pc_write = 1, pc_src = 1, jump = 1; back in FETCH on cycle 3.
- Illegal opcode 1111111 -> without the macro, FETCH after DECODE and retire_cnt unchanged; with MC_CTRL_ILLEGAL_TRAP_EN, state_o = 5 and illegal_o = 1 held for 10 cycles until arst_n pulse.
- Preload retire_cnt wrap (CNT_W = 4, 16 R-type instructions) -> retire_cnt returns to 0; assert arst_n in MEM of a STORE -> mem_write drops immediately, retire_cnt = 0.
